// File: rtl/ifns_nibble_serializer.sv
// Word-to-nibble serializer feeding the IFNS 4-bit encoder.
// Emits WORD_W/4 nibbles LSB-first, one per consumed cycle, with first/last flags.
module ifns_nibble_serializer #(
   parameter int          WORD_W   = 16,
   parameter logic [3:0]  IDLE_NIB = 4'h0
) (
   input  logic              clock,
   input  logic              rst,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [3:0]        out_nib,
   output logic              out_valid,
   output logic              out_first,
   output logic              out_last,
   input  logic              out_ready,
   output logic              busy
);

   localparam int NUM   = WORD_W / 4;
   localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM - 1);

   typedef enum logic {IDLE, SHIFT} state_e;

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [WORD_W-1:0]   sr_q, sr_d;
   logic [3:0]          nib_q, nib_d;
   logic                valid_q, valid_d;
   logic                first_q, first_d;
   logic                last_q, last_d;
   logic                accept;
   logic                consume;

   // Accept on the edge the last nibble leaves so words stream without a bubble.
   assign in_ready = !rst &&
                     (state_q == IDLE || (valid_q && last_q && out_ready));
   assign accept   = in_valid && in_ready;
   assign consume  = valid_q && out_ready;

   always_ff @(posedge clock) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         sr_q    <= '0;
         nib_q   <= IDLE_NIB;
         valid_q <= 1'b0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         sr_q    <= sr_d;
         nib_q   <= nib_d;
         valid_q <= valid_d;
         first_q <= first_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      sr_d    = sr_q;
      if (accept) begin
         state_d = SHIFT;
         idx_d   = '0;
         sr_d    = in_data;
      end else if (consume) begin
         if (idx_q == LAST) begin
            state_d = IDLE;
            idx_d   = '0;
            sr_d    = '0;
         end else begin
            idx_d = idx_q + IDX_W'(1);
            sr_d  = sr_q >> 4;
         end
      end
   end

   always_comb begin
      valid_d = (state_d == SHIFT);
      nib_d   = valid_d ? sr_d[3:0] : IDLE_NIB;
      first_d = valid_d && (idx_d == '0);
      last_d  = valid_d && (idx_d == LAST);
   end

   assign out_nib   = nib_q;
   assign out_valid = valid_q;
   assign out_first = first_q;
   assign out_last  = last_q;
   assign busy      = (state_q == SHIFT);

endmodule

// File: tb/tb_ifns_nibble_serializer.sv
// Bench for ifns_nibble_serializer: directed vector table, 8-bit variant,
// and random traffic against a nibble-queue reference model.
module tb_ifns_nibble_serializer;

   logic        clock = 1'b0;
   always #5 clock = ~clock;

   logic        rst, in_valid, out_ready;
   logic [15:0] in_data;
   logic        in_ready, out_valid, out_first, out_last, busy;
   logic [3:0]  out_nib;

   logic        rst8, iv8, or8;
   logic [7:0]  d8;
   logic        ir8, v8, f8, l8, b8;
   logic [3:0]  n8;

   ifns_nibble_serializer #(.WORD_W(16), .IDLE_NIB(4'h0)) dut (
      .clock(clock), .rst(rst), .in_data(in_data),
      .in_valid(in_valid), .in_ready(in_ready),
      .out_nib(out_nib), .out_valid(out_valid),
      .out_first(out_first), .out_last(out_last),
      .out_ready(out_ready), .busy(busy)
   );

   ifns_nibble_serializer #(.WORD_W(8), .IDLE_NIB(4'h5)) dut8 (
      .clock(clock), .rst(rst8), .in_data(d8),
      .in_valid(iv8), .in_ready(ir8),
      .out_nib(n8), .out_valid(v8),
      .out_first(f8), .out_last(l8),
      .out_ready(or8), .busy(b8)
   );

   typedef struct {
      logic        r;
      logic        iv;
      logic [15:0] d;
      logic        ordy;
      logic [3:0]  nib;
      logic        v, f, l, ir;
   } vec_t;

   vec_t tbl[$];
   int   nvec = 0;
   int   nerr = 0;

   function automatic void add(input logic r, iv, input logic [15:0] d,
                               input logic ordy, input logic [3:0] nib,
                               input logic v, f, l, ir);
      vec_t t;
      t.r = r; t.iv = iv; t.d = d; t.ordy = ordy;
      t.nib = nib; t.v = v; t.f = f; t.l = l; t.ir = ir;
      tbl.push_back(t);
   endfunction

   task automatic chk(input string nm, input logic [15:0] got, exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic drv(input logic r, iv, input logic [15:0] d,
                      input logic ordy);
      @(negedge clock);
      rst = r; in_valid = iv; in_data = d; out_ready = ordy;
      #1;
   endtask

   function automatic logic [15:0] obs16();
      return {7'd0, out_nib, out_valid, out_first, out_last, in_ready, busy};
   endfunction

   function automatic logic [15:0] obs8();
      return {7'd0, n8, v8, f8, l8, ir8, b8};
   endfunction

   function automatic logic [15:0] mk(input logic [3:0] nib,
                                      input logic v, f, l, ir);
      return {7'd0, nib, v, f, l, ir, v};
   endfunction

   logic [3:0]  q[$];
   logic [15:0] wq[$];
   logic [15:0] acc;
   int          cnt;

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      rst8 = 1'b1; iv8 = 1'b0; d8 = '0; or8 = 1'b1;
      repeat (2) @(posedge clock);

      // rst  iv  data      ordy | nib   v  f  l  ir
      add(1, 0, 16'h0000, 1, 4'h0, 0, 0, 0, 0);
      add(0, 1, 16'hA5C3, 1, 4'h0, 0, 0, 0, 1);
      add(0, 0, 16'h0000, 1, 4'h3, 1, 1, 0, 0);
      add(0, 0, 16'h0000, 1, 4'hC, 1, 0, 0, 0);
      add(0, 0, 16'h0000, 1, 4'h5, 1, 0, 0, 0);
      add(0, 0, 16'h0000, 1, 4'hA, 1, 0, 1, 1);
      add(0, 1, 16'h1234, 1, 4'h0, 0, 0, 0, 1);
      add(0, 1, 16'h5678, 1, 4'h4, 1, 1, 0, 0);
      add(0, 1, 16'h5678, 1, 4'h3, 1, 0, 0, 0);
      add(0, 1, 16'h5678, 1, 4'h2, 1, 0, 0, 0);
      add(0, 1, 16'h5678, 1, 4'h1, 1, 0, 1, 1);
      add(0, 0, 16'h0000, 1, 4'h8, 1, 1, 0, 0);
      add(0, 0, 16'h0000, 1, 4'h7, 1, 0, 0, 0);
      add(0, 0, 16'h0000, 1, 4'h6, 1, 0, 0, 0);
      add(0, 0, 16'h0000, 1, 4'h5, 1, 0, 1, 1);
      add(0, 1, 16'h1234, 1, 4'h0, 0, 0, 0, 1);
      add(0, 0, 16'h0000, 1, 4'h4, 1, 1, 0, 0);
      add(0, 0, 16'h0000, 1, 4'h3, 1, 0, 0, 0);
      add(0, 0, 16'h0000, 0, 4'h2, 1, 0, 0, 0);
      add(0, 0, 16'h0000, 0, 4'h2, 1, 0, 0, 0);
      add(0, 0, 16'h0000, 0, 4'h2, 1, 0, 0, 0);
      add(0, 0, 16'h0000, 1, 4'h2, 1, 0, 0, 0);
      add(0, 1, 16'h9999, 0, 4'h1, 1, 0, 1, 0);
      add(0, 0, 16'h0000, 1, 4'h1, 1, 0, 1, 1);
      add(0, 0, 16'h0000, 1, 4'h0, 0, 0, 0, 1);
      add(0, 1, 16'hBEEF, 1, 4'h0, 0, 0, 0, 1);
      add(0, 0, 16'h0000, 1, 4'hF, 1, 1, 0, 0);
      add(0, 0, 16'h0000, 1, 4'hE, 1, 0, 0, 0);
      add(1, 1, 16'h1111, 1, 4'hE, 1, 0, 0, 0);
      add(0, 1, 16'h0F0F, 1, 4'h0, 0, 0, 0, 1);
      add(0, 0, 16'h0000, 1, 4'hF, 1, 1, 0, 0);
      add(0, 0, 16'h0000, 1, 4'h0, 1, 0, 0, 0);
      add(0, 0, 16'h0000, 1, 4'hF, 1, 0, 0, 0);
      add(0, 0, 16'h0000, 1, 4'h0, 1, 0, 1, 1);
      add(0, 0, 16'h0000, 1, 4'h0, 0, 0, 0, 1);

      foreach (tbl[i]) begin
         drv(tbl[i].r, tbl[i].iv, tbl[i].d, tbl[i].ordy);
         chk($sformatf("vec%0d", i), obs16(),
             mk(tbl[i].nib, tbl[i].v, tbl[i].f, tbl[i].l, tbl[i].ir));
      end

      // 8-bit word, idle nibble 5
      @(negedge clock);
      rst8 = 1'b0; iv8 = 1'b1; d8 = 8'h9E; or8 = 1'b1;
      #1 chk("w8_idle", obs8(), mk(4'h5, 0, 0, 0, 1));
      @(negedge clock);
      iv8 = 1'b0;
      #1 chk("w8_nib0", obs8(), mk(4'hE, 1, 1, 0, 0));
      @(negedge clock);
      #1 chk("w8_nib1", obs8(), mk(4'h9, 1, 0, 1, 1));
      @(negedge clock);
      #1 chk("w8_after", obs8(), mk(4'h5, 0, 0, 0, 1));

      // random traffic against a queue of pending nibbles
      drv(1'b1, 1'b0, 16'h0, 1'b1);
      q.delete(); wq.delete(); acc = '0; cnt = 0;
      for (int c = 0; c < 10000; c++) begin
         logic        r, iv, ordy, mv, mir;
         logic [15:0] d;
         int          sz;
         r    = ($urandom_range(0, 299) == 0);
         iv   = ($urandom_range(0, 9) < 7);
         ordy = ($urandom_range(0, 3) != 0);
         d    = 16'($urandom);
         drv(r, iv, d, ordy);
         sz  = q.size();
         mv  = (sz > 0);
         mir = !r && (sz == 0 || (sz == 1 && ordy));
         chk($sformatf("rnd%0d", c), obs16(),
             mk(mv ? q[0] : 4'h0, mv, sz == 4, sz == 1, mir));
         if (r) begin
            q.delete(); wq.delete(); acc = '0; cnt = 0;
         end else begin
            if (mv && ordy) begin
               void'(q.pop_front());
               acc[cnt*4 +: 4] = out_nib;
               cnt++;
               if (cnt == 4) begin
                  if (wq.size() == 0) begin
                     nvec++; nerr++;
                     $display("FAIL word_extra got=%h exp=none", acc);
                  end else begin
                     chk("word", acc, wq.pop_front());
                  end
                  acc = '0; cnt = 0;
               end
            end
            if (iv && mir) begin
               for (int k = 0; k < 4; k++) q.push_back(d[k*4 +: 4]);
               wq.push_back(d);
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
